// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-frame controller.
package ccff_pkg;

    // Frame progress, decoded from the shift counter.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2,
        OVER    = 2'd3
    } frame_state_t;

    // Counter must reach DEPTH+1, its saturation value.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/ccff_lane.sv
// One configuration lane: a DEPTH-stage shadow shift chain and the active
// configuration register it commits into.
module ccff_lane #(
    parameter int DEPTH = 64
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             head,
    input  logic             shift,
    input  logic             load_active,
    input  logic             load_shadow,
    output logic             tail,
    output logic [DEPTH-1:0] active
);

    logic [DEPTH-1:0] shadow;

    // Shadow chain: readback reload wins over shifting; the oldest bit sits in DEPTH-1.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            // NOTE: these registers are reset because a reset must abort any partial frame.
            shadow <= '0;
        end else if (load_shadow) begin
            shadow <= active;
        end else if (shift) begin
            shadow <= {shadow[DEPTH-2:0], head};
        end
    end

    // Active configuration: replaced atomically on an accepted commit.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            active <= '0;
        end else if (load_active) begin
            active <= shadow;
        end
    end

    assign tail = shadow[DEPTH-1];

endmodule

// File: rtl/ccff_frame_ctrl.sv
// Configuration-frame controller: multi-lane shadow chains, a shared bit
// counter, atomic commit into the active configuration, and readback.
module ccff_frame_ctrl
    import ccff_pkg::*;
#(
    parameter int LANES = 1,
    parameter int DEPTH = 64
) (
    input  logic                   prog_clk,
    input  logic                   pReset,
    input  logic [LANES-1:0]       ccff_head,
    input  logic                   ccff_en,
    input  logic                   commit,
    input  logic                   readback,
    output logic [LANES-1:0]       ccff_tail,
    output logic [LANES*DEPTH-1:0] config_q,
    output logic                   frame_done,
    output logic                   commit_ok,
    output logic                   commit_err
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    frame_state_t  state;
    logic          do_shift;
    logic          load_active;
    logic          load_shadow;
    logic          ok_next;
    logic          err_next;

    // Frame state is a pure decode of the counter.
    always_comb begin
        if (cnt == '0) begin
            state = EMPTY;
        end else if (cnt < CNT_FULL) begin
            state = LOADING;
        end else if (cnt == CNT_FULL) begin
            state = FULL;
        end else begin
            state = OVER;
        end
    end

    // Request priority: commit, then readback, then shift; losers are dropped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        cnt_next    = cnt;
        do_shift    = 1'b0;
        load_active = 1'b0;
        load_shadow = 1'b0;
        ok_next     = 1'b0;
        err_next    = 1'b0;
        if (commit) begin
            cnt_next = '0;
            if (state == FULL) begin
                load_active = 1'b1;
                ok_next     = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end else if (readback) begin
            cnt_next    = '0;
            load_shadow = 1'b1;
        end else if (ccff_en) begin
            do_shift = 1'b1;
            if (state != OVER) begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // Counter and registered one-cycle commit result pulses.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            cnt        <= '0;
            commit_ok  <= 1'b0;
            commit_err <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            commit_ok  <= ok_next;
            commit_err <= err_next;
        end
    end

    assign frame_done = (state == FULL);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ccff_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .prog_clk    (prog_clk),
            .pReset      (pReset),
            .head        (ccff_head[l]),
            .shift       (do_shift),
            .load_active (load_active),
            .load_shadow (load_shadow),
            .tail        (ccff_tail[l]),
            .active      (config_q[l*DEPTH +: DEPTH])
        );
    end

endmodule

// File: tb/tb_ccff_frame_ctrl.sv
// Bench for ccff_frame_ctrl with LANES=2, DEPTH=4: directed scenarios plus
// random traffic, all outputs compared against a queue-based frame model.
module tb_ccff_frame_ctrl;

    localparam int L = 2;
    localparam int D = 4;
    localparam int W = L * D;

    logic         prog_clk = 1'b0;
    logic         pReset;
    logic [L-1:0] ccff_head;
    logic         ccff_en;
    logic         commit;
    logic         readback;
    logic [L-1:0] ccff_tail;
    logic [W-1:0] config_q;
    logic         frame_done;
    logic         commit_ok;
    logic         commit_err;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_cnt = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_frame_ctrl #(
        .LANES(L),
        .DEPTH(D)
    ) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .ccff_head  (ccff_head),
        .ccff_en    (ccff_en),
        .commit     (commit),
        .readback   (readback),
        .ccff_tail  (ccff_tail),
        .config_q   (config_q),
        .frame_done (frame_done),
        .commit_ok  (commit_ok),
        .commit_err (commit_err)
    );

    typedef struct {
        int           edge_no;
        logic [W-1:0] cfg;
        logic [L-1:0] tail;
        logic         fd;
        logic         ok;
        logic         err;
    } exp_t;

    exp_t sb[$];

    // Frame model: each lane's shadow is a queue with the newest bit at index 0.
    typedef bit bitq_t[$];
    bitq_t m_sh[L];
    bitq_t m_act[L];
    int    m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int l = 0; l < L; l++) begin
            m_sh[l]  = {};
            m_act[l] = {};
            for (int i = 0; i < D; i++) begin
                m_sh[l].push_back(1'b0);
                m_act[l].push_back(1'b0);
            end
        end
        m_cnt = 0;
    endfunction

    function automatic exp_t model_step(input logic en, input logic [L-1:0] head,
                                        input logic cm, input logic rb);
        exp_t e;
        e.ok  = 1'b0;
        e.err = 1'b0;
        if (cm) begin
            if (m_cnt == D) begin
                for (int l = 0; l < L; l++) m_act[l] = m_sh[l];
                e.ok = 1'b1;
            end else begin
                e.err = 1'b1;
            end
            m_cnt = 0;
        end else if (rb) begin
            for (int l = 0; l < L; l++) m_sh[l] = m_act[l];
            m_cnt = 0;
        end else if (en) begin
            for (int l = 0; l < L; l++) begin
                m_sh[l].push_front(head[l]);
                void'(m_sh[l].pop_back());
            end
            if (m_cnt <= D) m_cnt++;
        end
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < D; i++) e.cfg[l*D+i] = m_act[l][i];
            e.tail[l] = m_sh[l][D-1];
        end
        e.fd = (m_cnt == D);
        e.edge_no = 0;
        return e;
    endfunction

    always @(posedge prog_clk) edge_cnt++;

    // Monitor: compare every output against the expectation queued for the last edge.
    always @(negedge prog_clk) begin
        exp_t e;
        bit   matched;
        matched = 1'b0;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            matched = 1'b1;
            check("config_q",   config_q,   e.cfg);
            check("ccff_tail",  ccff_tail,  e.tail);
            check("frame_done", frame_done, e.fd);
            check("commit_ok",  commit_ok,  e.ok);
            check("commit_err", commit_err, e.err);
        end
        if (!matched && pReset === 1'b0) begin
            check("idle_pulses", {commit_ok, commit_err}, 2'b00);
        end
    end

    // Drive one cycle of requests and queue the expected response to that edge.
    task automatic step(input logic en, input logic [L-1:0] head,
                        input logic cm = 1'b0, input logic rb = 1'b0);
        exp_t e;
        ccff_en   = en;
        ccff_head = head;
        commit    = cm;
        readback  = rb;
        e = model_step(en, head, cm, rb);
        e.edge_no = edge_cnt + 1;
        sb.push_back(e);
        @(posedge prog_clk);
        #1;
        ccff_en   = 1'b0;
        ccff_head = '0;
        commit    = 1'b0;
        readback  = 1'b0;
    endtask

    task automatic settle();
        @(negedge prog_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] rb_seq;
        logic [L-1:0] frame_a[D];
        pReset    = 1'b0;
        ccff_en   = 1'b0;
        commit    = 1'b0;
        readback  = 1'b0;
        ccff_head = '0;
        model_reset();

        // Reset pulse between edges.
        #2 pReset = 1'b1;
        #2;
        check("rst_config_q",  config_q,   '0);
        check("rst_tail",      ccff_tail,  '0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_pulses",    {commit_ok, commit_err}, 2'b00);
        pReset = 1'b0;
        @(posedge prog_clk);
        #1;
        step(1'b0, '0);
        step(1'b0, '0);

        // Good frame: lane0 1,0,1,1 and lane1 0,0,0,1.
        frame_a[0] = 2'b01; frame_a[1] = 2'b00; frame_a[2] = 2'b01; frame_a[3] = 2'b11;
        for (int k = 0; k < D; k++) step(1'b1, frame_a[k]);
        settle();
        check("good_frame_done", frame_done, 1'b1);
        step(1'b0, '0, 1'b1);
        settle();
        check("good_commit_ok", commit_ok, 1'b1);
        check("good_config_q",  config_q,  8'h1B);
        check("good_fd_clear",  frame_done, 1'b0);

        // Short frame.
        for (int k = 0; k < D-1; k++) step(1'b1, 2'(k));
        step(1'b0, '0, 1'b1);
        settle();
        check("short_commit_err", commit_err, 1'b1);
        check("short_config_q",   config_q,   8'h1B);

        // Long frame.
        for (int k = 0; k < D+1; k++) step(1'b1, 2'b10);
        settle();
        check("long_frame_done", frame_done, 1'b0);
        step(1'b0, '0, 1'b1);
        settle();
        check("long_commit_err", commit_err, 1'b1);

        // Readback streams the old configuration out while zeros shift in.
        rb_seq = 4'b1101;
        step(1'b0, '0, 1'b0, 1'b1);
        settle();
        check("rb_tail0", ccff_tail[0], rb_seq[0]);
        for (int k = 1; k < D; k++) begin
            step(1'b1, '0);
            settle();
            check($sformatf("rb_tail%0d", k), ccff_tail[0], rb_seq[k]);
        end
        step(1'b1, '0);
        step(1'b0, '0, 1'b1);
        settle();
        check("rb_commit_ok", commit_ok, 1'b1);
        check("rb_config_q",  config_q,  8'h00);

        // Commit together with a shift in FULL: shift is dropped, counter clears.
        for (int k = 0; k < D; k++) step(1'b1, 2'($urandom));
        step(1'b1, 2'b11, 1'b1);
        settle();
        check("same_commit_ok", commit_ok, 1'b1);
        check("same_fd",        frame_done, 1'b0);
        for (int k = 0; k < D; k++) step(1'b1, 2'($urandom));
        settle();
        check("same_refill_fd", frame_done, 1'b1);

        // Readback together with a shift.
        step(1'b1, 2'b11, 1'b0, 1'b1);
        for (int k = 0; k < D; k++) step(1'b1, 2'($urandom));
        step(1'b0, '0, 1'b1);

        // Mid-frame asynchronous reset.
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        settle();
        pReset = 1'b1;
        #1;
        check("mid_rst_config_q", config_q,  '0);
        check("mid_rst_tail",     ccff_tail, '0);
        check("mid_rst_fd",       frame_done, 1'b0);
        model_reset();
        #1 pReset = 1'b0;
        for (int k = 0; k < D; k++) step(1'b1, 2'($urandom));
        step(1'b0, '0, 1'b1);
        settle();
        check("mid_rst_commit_ok", commit_ok, 1'b1);

        // Random traffic, biased so that commits in FULL happen often.
        repeat (400) begin
            logic en, cm, rb;
            en = ($urandom_range(0, 9) < 7);
            cm = (m_cnt == D) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
            rb = ($urandom_range(0, 15) == 0);
            step(en, 2'($urandom), cm, rb);
        end

        repeat (3) @(negedge prog_clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ccff_frame_ctrl.md
# ccff_frame_ctrl

Parametrised configuration-frame controller for grid tiles. It replaces the bare configuration-chain pass-through with a multi-lane shadow shift chain, a bit counter and an atomic commit to the active configuration. It also provides readback of the committed configuration. It sits between the tile's configuration-chain head/tail ports and the configuration inputs of the tile's logical blocks.

## Interface
- LANES, default 1: number of parallel configuration-chain lanes.
- DEPTH, default 64: configuration bits per lane; must be 2 or more.
- prog_clk  in  1  programming clock; all state changes on its rising edge.
- pReset  in  1  reset, asynchronous, active-high.
- ccff_head  in  LANES  serial configuration data, one bit per lane.
- ccff_en  in  1  shift enable.
- commit  in  1  request to copy the shadow chain into the active configuration.
- readback  in  1  request to load the active configuration into the shadow chain.
- ccff_tail  out  LANES  last shadow stage of each lane, driven directly by a flop.
- config_q  out  LANES*DEPTH  active configuration; bit l*DEPTH+i is lane l, stage i.
- frame_done  out  1  high while bit count == DEPTH.
- commit_ok  out  1  one-cycle pulse: a commit succeeded.
- commit_err  out  1  one-cycle pulse: a commit was rejected.

## Operation
- Each lane has a DEPTH-bit shadow register sh[l][0..DEPTH-1]. A shift sets sh[0] <= ccff_head[l] and sh[i] <= sh[i-1]. The first bit shifted in ends up in stage DEPTH-1.
- ccff_tail[l] = sh[l][DEPTH-1].
- Bit counter cnt counts shifts from 0 and saturates at DEPTH+1. Every lane shifts together, so there is a single counter.
- States:
  - EMPTY: cnt == 0.
  - LOADING: 0 < cnt < DEPTH.
  - FULL: cnt == DEPTH.
  - OVER: cnt > DEPTH.
  - ccff_en advances the state EMPTY→LOADING→FULL→OVER. Both commit and readback return the state to EMPTY.
- commit in state FULL:
  - active <= shadow; commit_ok pulses; cnt <= 0.
  - The shadow is unchanged.
- commit in any other state:
  - commit_err pulses; active is unchanged; cnt <= 0.
  - The shadow is unchanged.
- readback:
  - shadow <= active; cnt <= 0.
  - DEPTH further shifts then stream out the old configuration on ccff_tail while new bits shift in. A following commit then succeeds.
- Priority within one cycle:
  - commit beats readback, and readback beats ccff_en.
  - A lower-priority request in the same cycle is dropped. It is not queued.
- A commit while in EMPTY, including back-to-back commits, gives commit_err.

## Timing
- Reset values: shadow, active, config_q, ccff_tail, cnt, commit_ok and commit_err are all 0. State is EMPTY.
- Reset takes effect immediately, with no clock needed. It also aborts a partial frame: the shadow is cleared and active is cleared.
- config_q changes on the same edge that samples commit, so commit-to-config_q latency is 1 edge.
- commit_ok and commit_err are registered. Each goes high for exactly one cycle after that edge.
- ccff_tail is valid one edge after each shift or readback.
- frame_done is decoded from the cnt register. It goes high after the DEPTH-th shift edge and low after the next shift, commit or readback.
- Requests need no handshake. Each input is sampled every edge and treated as a level-per-cycle request.

## Structure
- Package ccff_pkg holds:
  - the state enum (EMPTY, LOADING, FULL, OVER);
  - the counter width function, clog2(DEPTH+2).
- Sub-module ccff_lane is instantiated LANES times by generate. It holds one lane's shadow and active registers and has shift, load-active and load-shadow controls.
- The top level holds the counter, the state decode, the priority logic and the pulse flops.

## Test plan
All scenarios use LANES=2, DEPTH=4.
- Reset: pulse pReset between clock edges. config_q=8'h00, ccff_tail=2'b00, frame_done=0, and no pulses follow.
- Good frame: 4 shifts with lane0 head 1,0,1,1 and lane1 head 0,0,0,1. frame_done=1 after the 4th shift. Then commit. Result: commit_ok for one cycle, config_q=8'h1B, frame_done=0.
- Short frame and long frame:
  - 3 shifts then commit gives commit_err with config_q held at 8'h1B.
  - 5 shifts gives frame_done=0 after the 5th; a commit then gives commit_err.
- Readback: from config_q=8'h1B, assert readback, then shift in zeros. Lane0 ccff_tail reads 1,0,1,1 at the readback edge and after shifts 1–3. After 4 shifts, commit gives commit_ok and config_q=8'h00.
- Same-cycle requests:
  - commit with ccff_en in state FULL: commit_ok, and cnt=0 afterwards with the shift dropped.
  - readback with ccff_en: the shadow equals active, cnt=0.
- Mid-frame reset: assert pReset asynchronously after 2 shifts. Outputs clear at once. After release, 4 new shifts plus commit give commit_ok.
